// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and the
// default tick-counter width.
package btn_debounce_pkg;

    localparam int N_DEFAULT = 19;

    typedef enum logic [2:0] {
        ZERO    = 3'd0,
        WAIT1_1 = 3'd1,
        WAIT1_2 = 3'd2,
        WAIT1_3 = 3'd3,
        ONE     = 3'd4,
        WAIT0_1 = 3'd5,
        WAIT0_2 = 3'd6,
        WAIT0_3 = 3'd7
    } db_state_t;

endpackage

// File: rtl/btn_debounce_if.sv
// Button bus between the raw push-buttons and the debounced consumer.
// The master drives the raw levels; the slave (the debouncer) returns level and edge.
interface btn_debounce_if #(
    parameter int NUM_BTN = 2
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] db_level;
    logic [NUM_BTN-1:0] db_tick;

    modport master (output btn_raw, input db_level, input db_tick);
    modport slave  (input btn_raw, output db_level, output db_tick);
endinterface

// File: rtl/debounce_fsm.sv
// Debounce state machine for one button, paced by the shared m_tick.
// state   | meaning
// ZERO    | released, stable
// WAIT1_k | input high, k-1 ticks seen so far while waiting to accept a press
// ONE     | pressed, stable
// WAIT0_k | input low, k-1 ticks seen so far while waiting to accept a release
module debounce_fsm
    import btn_debounce_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic m_tick,
    input  logic btn_sync,
    output logic db_level,
    output logic db_tick
);

    db_state_t state;

    // Outputs follow the next state; the level only changes on the two accepting transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ZERO;
            db_level <= 1'b0;
            db_tick  <= 1'b0;
        end else begin
            db_tick <= 1'b0;
            case (state)
                ZERO:    if (btn_sync) state <= WAIT1_1;
                WAIT1_1: if (!btn_sync) state <= ZERO; else if (m_tick) state <= WAIT1_2;
                WAIT1_2: if (!btn_sync) state <= ZERO; else if (m_tick) state <= WAIT1_3;
                WAIT1_3: begin
                    if (!btn_sync) begin
                        state <= ZERO;
                    end else if (m_tick) begin
                        state    <= ONE;
                        db_level <= 1'b1;
                        db_tick  <= 1'b1;
                    end
                end
                ONE:     if (!btn_sync) state <= WAIT0_1;
                WAIT0_1: if (btn_sync) state <= ONE; else if (m_tick) state <= WAIT0_2;
                WAIT0_2: if (btn_sync) state <= ONE; else if (m_tick) state <= WAIT0_3;
                WAIT0_3: begin
                    if (btn_sync) begin
                        state <= ONE;
                    end else if (m_tick) begin
                        state    <= ZERO;
                        db_level <= 1'b0;
                    end
                end
                default: begin
                    state    <= ZERO;
                    db_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-FF synchronisers, a shared debounce tick counter,
// and one debounce FSM per button.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int NUM_BTN = 2
) (
    input  logic                clk,
    input  logic                reset,
    btn_debounce_if.slave       bus
);

    logic [NUM_BTN-1:0] sync_meta;
    logic [NUM_BTN-1:0] btn_sync;
    logic [N-1:0]       count;
    logic               m_tick;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            btn_sync  <= '0;
        end else begin
            sync_meta <= bus.btn_raw;
            btn_sync  <= sync_meta;
        end
    end

    // Free-running; natural wrap gives one m_tick every 2^N clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count <= '0;
        else       count <= count + 1'b1;
    end

    assign m_tick = (count == '1);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_fsm u_fsm (
            .clk      (clk),
            .reset    (reset),
            .m_tick   (m_tick),
            .btn_sync (btn_sync[i]),
            .db_level (level[i]),
            .db_tick  (tick[i])
        );
    end

    assign bus.db_level = level;
    assign bus.db_tick  = tick;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with N=3 and two buttons, using a
// tick-counting reference model of the debounce rules.
module tb_btn_debounce;

    localparam int N   = 3;
    localparam int NB  = 2;
    localparam int PER = 1 << N;

    logic clk = 1'b0;
    logic reset = 1'b1;

    btn_debounce_if #(.NUM_BTN(NB)) bif ();

    btn_debounce #(.N(N), .NUM_BTN(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: raw input delayed two clocks, then a change is accepted
    // once the synchronised value has differed from the level through 3 ticks.
    logic [NB-1:0] s1, s2, m_level, m_tick_o;
    int            cyc;
    bit            m_wait [NB];
    int            m_ticks[NB];

    task automatic mreset();
        s1 = '0; s2 = '0; m_level = '0; m_tick_o = '0; cyc = 0;
        for (int i = 0; i < NB; i++) begin
            m_wait[i] = 1'b0;
            m_ticks[i] = 0;
        end
    endtask

    task automatic mupdate();
        bit tk;
        tk = ((cyc % PER) == PER - 1);
        m_tick_o = '0;
        for (int i = 0; i < NB; i++) begin
            if (!m_wait[i]) begin
                if (s2[i] != m_level[i]) begin
                    m_wait[i] = 1'b1;
                    m_ticks[i] = 0;
                end
            end else if (s2[i] == m_level[i]) begin
                m_wait[i] = 1'b0;
            end else if (tk) begin
                m_ticks[i]++;
                if (m_ticks[i] == 3) begin
                    m_level[i] = ~m_level[i];
                    m_wait[i] = 1'b0;
                    if (m_level[i]) m_tick_o[i] = 1'b1;
                end
            end
        end
        s2 = s1;
        s1 = bif.btn_raw;
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) mreset();
        else mupdate();
        #1;
    endtask

    task automatic do_reset();
        bif.btn_raw = '0;
        reset = 1'b1;
        mreset();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bif.btn_raw = 2'b11;
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            n_cmp++;
            if ({bif.db_level, bif.db_tick} !== {m_level, m_tick_o}) begin
                n_bad++;
                $display("FAIL reset_pre step %0d: level/tick got %b/%b want %b/%b",
                         k, bif.db_level, bif.db_tick, m_level, m_tick_o);
            end
        end
        #2 reset = 1'b1;
        mreset();
        #1;
        n_cmp++;
        if (bif.db_level !== 2'b00 || bif.db_tick !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_async: level/tick got %b/%b want 00/00", bif.db_level, bif.db_tick);
        end
        step();
        reset = 1'b0;
        for (int k = 0; k < 18; k++) begin
            step();
            n_cmp++;
            if (bif.db_level !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_hold step %0d: level got %b want 00", k, bif.db_level);
            end
        end
        do_reset();
    endtask

    task automatic test_clean_press();
        int rise = 0;
        int ticks = 0;
        bif.btn_raw = 2'b01;
        for (int k = 1; k <= 40; k++) begin
            step();
            n_cmp++;
            if ({bif.db_level, bif.db_tick} !== {m_level, m_tick_o}) begin
                n_bad++;
                $display("FAIL press_model step %0d: level/tick got %b/%b want %b/%b",
                         k, bif.db_level, bif.db_tick, m_level, m_tick_o);
            end
            if (rise == 0 && bif.db_level[0]) rise = k;
            if (bif.db_tick[0]) ticks++;
        end
        n_cmp++;
        if (rise < 19 || rise > 27) begin
            n_bad++;
            $display("FAIL press_latency: got %0d clocks want 19..27", rise);
        end
        n_cmp++;
        if (ticks != 1) begin
            n_bad++;
            $display("FAIL press_tick_count: got %0d want 1", ticks);
        end
        n_cmp++;
        if (bif.db_level !== 2'b01) begin
            n_bad++;
            $display("FAIL press_bit1: level got %b want 01", bif.db_level);
        end
    endtask

    task automatic test_release_glitch();
        int fall = 0;
        int ticks = 0;
        int drops = 0;
        bif.btn_raw[0] = 1'b0;
        for (int k = 0; k < 36; k++) begin
            if (k == 6) bif.btn_raw[0] = 1'b1;
            step();
            n_cmp++;
            if ({bif.db_level, bif.db_tick} !== {m_level, m_tick_o}) begin
                n_bad++;
                $display("FAIL glitch_model step %0d: level/tick got %b/%b want %b/%b",
                         k, bif.db_level, bif.db_tick, m_level, m_tick_o);
            end
            if (!bif.db_level[0]) drops++;
            if (bif.db_tick[0]) ticks++;
        end
        n_cmp++;
        if (drops != 0 || ticks != 0) begin
            n_bad++;
            $display("FAIL glitch_reject: low clocks %0d ticks %0d want 0/0", drops, ticks);
        end
        bif.btn_raw[0] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            n_cmp++;
            if ({bif.db_level, bif.db_tick} !== {m_level, m_tick_o}) begin
                n_bad++;
                $display("FAIL release_model step %0d: level/tick got %b/%b want %b/%b",
                         k, bif.db_level, bif.db_tick, m_level, m_tick_o);
            end
            if (fall == 0 && !bif.db_level[0]) fall = k;
        end
        n_cmp++;
        if (fall < 19 || fall > 27) begin
            n_bad++;
            $display("FAIL release_latency: got %0d clocks want 19..27", fall);
        end
    endtask

    task automatic test_bounce();
        int seen = 0;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 8; k++) begin
                bif.btn_raw[1] = (k < 5);
                step();
                n_cmp++;
                if ({bif.db_level, bif.db_tick} !== {m_level, m_tick_o}) begin
                    n_bad++;
                    $display("FAIL bounce_model pulse %0d: level/tick got %b/%b want %b/%b",
                             p, bif.db_level, bif.db_tick, m_level, m_tick_o);
                end
                if (bif.db_level[1] || bif.db_tick[1]) seen++;
            end
        end
        bif.btn_raw[1] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bif.db_level[1] || bif.db_tick[1]) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL bounce_reject: asserted clocks %0d want 0", seen);
        end
    endtask

    task automatic test_simultaneous();
        int rise0 = 0, rise1 = 0, t0 = 0, t1 = 0;
        do_reset();
        bif.btn_raw = 2'b11;
        for (int k = 1; k <= 40; k++) begin
            step();
            n_cmp++;
            if ({bif.db_level, bif.db_tick} !== {m_level, m_tick_o}) begin
                n_bad++;
                $display("FAIL simul_model step %0d: level/tick got %b/%b want %b/%b",
                         k, bif.db_level, bif.db_tick, m_level, m_tick_o);
            end
            if (rise0 == 0 && bif.db_level[0]) rise0 = k;
            if (rise1 == 0 && bif.db_level[1]) rise1 = k;
            if (bif.db_tick[0]) t0++;
            if (bif.db_tick[1]) t1++;
        end
        n_cmp++;
        if (rise0 == 0 || rise0 != rise1 || t0 != 1 || t1 != 1) begin
            n_bad++;
            $display("FAIL simul_rise: rise %0d/%0d ticks %0d/%0d want equal nonzero, 1/1",
                     rise0, rise1, t0, t1);
        end
    endtask

    task automatic test_reset_mid();
        int found = 0;
        int rise = 0;
        do_reset();
        bif.btn_raw = 2'b01;
        for (int k = 0; k < 40 && found == 0; k++) begin
            step();
            if (m_wait[0] && m_ticks[0] == 1) found = 1;
        end
        n_cmp++;
        if (found == 0) begin
            n_bad++;
            $display("FAIL midrst_reach: WAIT1_2 not reached got 0 want 1");
        end
        #2 reset = 1'b1;
        mreset();
        #1;
        n_cmp++;
        if (bif.db_level !== 2'b00 || bif.db_tick !== 2'b00) begin
            n_bad++;
            $display("FAIL midrst_async: level/tick got %b/%b want 00/00", bif.db_level, bif.db_tick);
        end
        step();
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            n_cmp++;
            if ({bif.db_level, bif.db_tick} !== {m_level, m_tick_o}) begin
                n_bad++;
                $display("FAIL midrst_model step %0d: level/tick got %b/%b want %b/%b",
                         k, bif.db_level, bif.db_tick, m_level, m_tick_o);
            end
            if (rise == 0 && bif.db_level[0]) rise = k;
        end
        n_cmp++;
        if (rise < 19 || rise > 27) begin
            n_bad++;
            $display("FAIL midrst_latency: got %0d clocks want 19..27", rise);
        end
    endtask

    task automatic test_random();
        int remain[NB];
        do_reset();
        for (int i = 0; i < NB; i++) remain[i] = $urandom_range(1, 30);
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < NB; i++) begin
                remain[i]--;
                if (remain[i] <= 0) begin
                    bif.btn_raw[i] = ~bif.btn_raw[i];
                    remain[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7)
                                                            : $urandom_range(8, 40);
                end
            end
            step();
            n_cmp++;
            if ({bif.db_level, bif.db_tick} !== {m_level, m_tick_o}) begin
                n_bad++;
                $display("FAIL random_model step %0d: level/tick got %b/%b want %b/%b",
                         k, bif.db_level, bif.db_tick, m_level, m_tick_o);
            end
        end
    endtask

    initial begin
        bif.btn_raw = '0;
        mreset();
        step();
        step();
        test_reset();
        test_clean_press();
        test_release_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
